tile_write_scheduler: RTL and testbench



---
 rtl/tile_write_scheduler.sv | 261 ++++++++++++++++++++++++++
 tb/tb_tile_write_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_write_scheduler.sv
// Host tile-write queue plus rectangle-fill engine, arbitrated onto one tile-memory write port.
// Issue is one registered cycle after acceptance; writes are held off while the commit window is closed.
module tile_write_scheduler #(
  parameter int FIFO_DEPTH = 8,
  parameter int COLS       = 80,
  parameter int ROWS       = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        vblank,
  output logic        tm_we,
  output logic [12:0] tm_addr,
  output logic [5:0]  tm_data,
  output logic        fill_done
);
  localparam int MEM = COLS * ROWS;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [12:0] addr;
    logic [5:0]  id;
  } tile_wr_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_t;

  fill_state_t state, state_next;

  logic        host_wr, data_wr, go_wr;
  logic [12:0] cur_addr;
  logic        vblank_only, ovf, err;
  logic [6:0]  x0, w;
  logic [5:0]  y0, h;

  logic [6:0]  x_first, x_last, col;
  logic [5:0]  y_last, row;
  logic [12:0] row_base;
  logic [5:0]  fill_id;

  logic [7:0]  x_sum;
  logic [6:0]  y_sum;
  logic [6:0]  x_last_next;
  logic [5:0]  y_last_next;

  logic        open, busy, addr_ok, go_ok, go_accept, last_tile;
  logic        fifo_push, fifo_pop, fifo_empty, fifo_full, fill_issue;
  tile_wr_t    fifo_din, fifo_dout;
  logic [CW-1:0] fifo_cnt;
  logic [31:0] cnt_wide;
  logic [15:0] status;
  logic        unused_bits;

  assign unused_bits = ^writedata[15:13];

  assign host_wr = chipselect & write;
  assign data_wr = host_wr & (address == 3'd1);
  assign go_wr   = host_wr & (address == 3'd4);

  assign busy       = (state != IDLE);
  assign open       = ~vblank_only | vblank;
  assign fifo_pop   = open & ~fifo_empty;
  assign fill_issue = open & fifo_empty & (state == RUN);

  // A full queue still accepts a push when an entry leaves in the same cycle.
  assign addr_ok   = (cur_addr < 13'(MEM));
  assign fifo_push = data_wr & addr_ok & (~fifo_full | fifo_pop);
  assign fifo_din  = '{addr: cur_addr, id: writedata[5:0]};

  assign go_ok     = ~busy && (w != 7'd0) && (h != 6'd0) &&
                     (x0 < 7'(COLS)) && (y0 < 6'(ROWS));
  assign go_accept = go_wr & go_ok;
  assign last_tile = (col == x_last) && (row == y_last);

  always_comb begin
    x_sum       = {1'b0, x0} + {1'b0, w};
    y_sum       = {1'b0, y0} + {1'b0, h};
    x_last_next = (x_sum >= 8'(COLS)) ? 7'(COLS - 1) : 7'(x_sum - 8'd1);
    y_last_next = (y_sum >= 7'(ROWS)) ? 6'(ROWS - 1) : 6'(y_sum - 7'd1);
  end

  sync_fifo #(
    .WIDTH($bits(tile_wr_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go_accept) state_next = RUN;
      RUN:     if (fill_issue && last_tile) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fill walker: raster order inside the clipped rectangle.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_first  <= '0;
      x_last   <= '0;
      y_last   <= '0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      fill_id  <= '0;
    end else if (go_accept) begin
      x_first  <= x0;
      x_last   <= x_last_next;
      y_last   <= y_last_next;
      col      <= x0;
      row      <= y0;
      row_base <= 13'(y0) * 13'(COLS);
      fill_id  <= writedata[5:0];
    end else if (fill_issue) begin
      if (col == x_last) begin
        col      <= x_first;
        row      <= row + 6'd1;
        row_base <= row_base + 13'(COLS);
      end else begin
        col <= col + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr    <= '0;
      vblank_only <= 1'b0;
      ovf         <= 1'b0;
      err         <= 1'b0;
      x0          <= '0;
      y0          <= '0;
      w           <= '0;
      h           <= '0;
    end else if (host_wr) begin
      case (address)
        3'd0: cur_addr <= writedata[12:0];
        3'd1: begin
          if (!addr_ok)        err <= 1'b1;
          else if (!fifo_push) ovf <= 1'b1;
          else cur_addr <= (cur_addr == 13'(MEM - 1)) ? 13'd0 : cur_addr + 13'd1;
        end
        3'd2: begin
          x0 <= writedata[6:0];
          y0 <= writedata[12:7];
        end
        3'd3: begin
          w <= writedata[6:0];
          h <= writedata[12:7];
        end
        3'd4: if (!go_ok) err <= 1'b1;
        3'd5: begin
          vblank_only <= writedata[0];
          if (writedata[1]) begin
            ovf <= 1'b0;
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_wide      = 32'(fifo_cnt);
    status        = '0;
    status[0]     = busy;
    status[1]     = fifo_empty;
    status[2]     = fifo_full;
    status[3]     = ovf;
    status[4]     = err;
    status[11:8]  = (cnt_wide > 32'd15) ? 4'hF : cnt_wide[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tm_we     <= 1'b0;
      tm_addr   <= '0;
      tm_data   <= '0;
      fill_done <= 1'b0;
      readdata  <= '0;
    end else begin
      tm_we     <= fifo_pop | fill_issue;
      fill_done <= (state == DONE);
      if (fifo_pop) begin
        tm_addr <= fifo_dout.addr;
        tm_data <= fifo_dout.id;
      end else if (fill_issue) begin
        tm_addr <= row_base + 13'(col);
        tm_data <= fill_id;
      end
      if (chipselect && read) readdata <= (address == 3'd6) ? status : 16'd0;
    end
  end
endmodule

// Generic single-clock FIFO; dout shows the head entry combinationally.
// Caller must not push when full without a simultaneous pop, nor pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
endmodule

// File: tb/tb_tile_write_scheduler.sv
// Directed bench for tile_write_scheduler: expected tile writes are queued by the stimulus
// and a negedge monitor matches every tm_we cycle against them in order.
module tb_tile_write_scheduler;
  logic        clk = 1'b0;
  logic        reset, chipselect, write, read, vblank;
  logic [2:0]  address;
  logic [15:0] writedata, readdata;
  logic        tm_we, fill_done;
  logic [12:0] tm_addr;
  logic [5:0]  tm_data;

  typedef struct packed {
    logic [12:0] addr;
    logic [5:0]  id;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  logic        prev_we = 1'b0;
  logic [12:0] prev_addr = '0;
  logic [12:0] exp_last_fill = '0;

  always #10 clk = ~clk;

  tile_write_scheduler #(.FIFO_DEPTH(8), .COLS(80), .ROWS(60)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .vblank     (vblank),
    .tm_we      (tm_we),
    .tm_addr    (tm_addr),
    .tm_data    (tm_data),
    .fill_done  (fill_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (tm_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0d id=%0d expected no write", tm_addr, tm_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(tm_addr), 32'(e.addr));
        check("wr_id", 32'(tm_data), 32'(e.id));
      end
    end
    if (fill_done === 1'b1) begin
      done_cnt++;
      check("done_after_last_write", {prev_we, prev_addr}, {1'b1, exp_last_fill});
    end
    prev_we   = tm_we;
    prev_addr = tm_addr;
  end

  task automatic exp_wr(input int a, input int id);
    exp_q.push_back(wr_t'{13'(a), 6'(id)});
  endtask

  task automatic hw(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd_status(input string name, input logic [15:0] exp);
    chipselect = 1'b1; read = 1'b1; address = 3'd6;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    check(name, 32'(readdata), 32'(exp));
  endtask

  task automatic wait_drain(input string name, input int budget, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int cyc;
    int wr_base;
    logic [15:0] bad_pos  [4];
    logic [15:0] bad_size [4];
    bad_pos  = '{16'd0, 16'd0, 16'd80, 16'(60 << 7)};
    bad_size = '{16'(1 << 7), 16'd1, 16'(1 | (1 << 7)), 16'(1 | (1 << 7))};

    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    vblank = 1'b0; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_tm_we", 32'(tm_we), 0);
    check("rst_tm_addr", 32'(tm_addr), 0);
    check("rst_tm_data", 32'(tm_data), 0);
    check("rst_readdata", 32'(readdata), 0);
    check("rst_fill_done", 32'(fill_done), 0);
    rd_status("rst_status", 16'h0002);

    // Address wrap at the last tile, and one-cycle issue latency.
    hw(3'd0, 16'd4799);
    exp_wr(4799, 5);
    exp_wr(0, 7);
    hw(3'd1, 16'd5);
    check("data_lat_k", 32'(tm_we), 0);
    hw(3'd1, 16'd7);
    check("data_lat_k1", 32'(tm_we), 1);
    wait_drain("t1_drain", 20, cyc);
    rd_status("t1_status", 16'h0002);

    // Window closed: queue fills, ninth push overflows, then drains in order.
    hw(3'd5, 16'd1);
    hw(3'd0, 16'd10);
    for (int i = 0; i < 9; i++) hw(3'd1, 16'(i + 1));
    repeat (3) @(negedge clk);
    rd_status("t2_full_status", 16'h080C);
    for (int i = 0; i < 8; i++) exp_wr(10 + i, i + 1);
    vblank = 1'b1;
    wait_drain("t2_drain", 20, cyc);
    check("t2_consecutive", 32'(cyc), 8);
    rd_status("t2_ovf_sticky", 16'h000A);
    hw(3'd5, 16'd2);
    vblank = 1'b0;
    rd_status("t2_cleared", 16'h0002);
    exp_wr(18, 33);
    hw(3'd1, 16'd33);
    wait_drain("t2_addr_kept", 20, cyc);

    // Corner fill clipped to 2x2.
    exp_last_fill = 13'd4799;
    exp_wr(4718, 11); exp_wr(4719, 11); exp_wr(4798, 11); exp_wr(4799, 11);
    hw(3'd2, 16'(78 | (58 << 7)));
    hw(3'd3, 16'(4 | (4 << 7)));
    hw(3'd4, 16'd11);
    check("fill_lat_k", 32'(tm_we), 0);
    rd_status("t3_busy", 16'h0003);
    check("fill_lat_k1", 32'(tm_we), 1);
    wait_drain("t3_drain", 20, cyc);
    repeat (3) @(negedge clk);
    check("t3_done_cnt", 32'(done_cnt), 1);
    rd_status("t3_idle", 16'h0002);

    // Rejected fills set err and issue nothing.
    for (int i = 0; i < 4; i++) begin
      hw(3'd2, bad_pos[i]);
      hw(3'd3, bad_size[i]);
      hw(3'd4, 16'd5);
      repeat (3) @(negedge clk);
      rd_status("t4_bad_go_err", 16'h0012);
      hw(3'd5, 16'd2);
      rd_status("t4_err_clear", 16'h0002);
    end

    // Busy GO and out-of-range DATA do not disturb a running 10x2 fill.
    hw(3'd2, 16'd0);
    hw(3'd3, 16'(10 | (2 << 7)));
    for (int i = 0; i < 10; i++) exp_wr(i, 3);
    for (int i = 0; i < 10; i++) exp_wr(80 + i, 3);
    exp_last_fill = 13'd89;
    hw(3'd4, 16'd3);
    hw(3'd4, 16'd9);
    hw(3'd0, 16'd4800);
    hw(3'd1, 16'd1);
    wait_drain("t4_drain", 60, cyc);
    repeat (3) @(negedge clk);
    check("t4_done_cnt", 32'(done_cnt), 2);
    rd_status("t4_err_set", 16'h0012);
    hw(3'd5, 16'd2);
    rd_status("t4_err_clear2", 16'h0002);

    // Queued write preempts a running fill for one cycle.
    wr_base = wr_cnt;
    hw(3'd3, 16'(10 | (1 << 7)));
    exp_wr(0, 4); exp_wr(1, 4); exp_wr(100, 55);
    for (int i = 2; i < 10; i++) exp_wr(i, 4);
    exp_last_fill = 13'd9;
    hw(3'd4, 16'd4);
    hw(3'd0, 16'd100);
    hw(3'd1, 16'd55);
    wait_drain("t5_drain", 40, cyc);
    repeat (3) @(negedge clk);
    check("t5_total_writes", 32'(wr_cnt - wr_base), 11);
    check("t5_done_cnt", 32'(done_cnt), 3);

    // Reset on the third cycle of a 20-tile fill aborts it.
    hw(3'd3, 16'(20 | (1 << 7)));
    exp_wr(0, 6); exp_wr(1, 6);
    hw(3'd4, 16'd6);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_we", 32'(tm_we), 0);
    check("t6_rst_addr", 32'(tm_addr), 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_queue_empty", 32'(exp_q.size()), 0);
    check("t6_no_done", 32'(done_cnt), 3);
    rd_status("t6_status", 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
